// File: rtl/arbitro_memoria_pkg.sv
// -----------------------------------------------------------------------------
// arb_mem_pkg -- shared definitions for the arbitro_memoria slice.
//   DATA_WIDTH / ADDR_WIDTH : default RAM word and address widths
//   REQ_FETCH / REQ_LS      : requester indices (instruction fetch, load/store)
//   req_bundle_t            : one requester's request (req, we, addr, wdata)
//   sat_add16               : saturating add used by the optional conflict
//                             counter (ARB_MEM_STATS_EN)
// -----------------------------------------------------------------------------
package arb_mem_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int ADDR_WIDTH = 6;

  localparam int REQ_FETCH = 0;
  localparam int REQ_LS    = 1;

  typedef struct packed {
    logic                  req;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } req_bundle_t;

  // Adds a small increment to a 16-bit count, clamping at 16'hFFFF.
  function automatic logic [15:0] sat_add16(input logic [15:0] base,
                                            input logic [1:0]  inc);
    logic [16:0] sum;
    sum = {1'b0, base} + {15'd0, inc};
    if (sum[16]) begin
      sat_add16 = 16'hFFFF;
    end else begin
      sat_add16 = sum[15:0];
    end
  endfunction

endpackage

// File: rtl/arbitro_memoria_if.sv
// -----------------------------------------------------------------------------
// arbitro_memoria_if -- bus between the two requesters, the arbiter and the
// 8x64 dual-address RAM.
//   Requester i : req_i, we_i, addr_i, wdata_i (to arbiter);
//                 gnt_i, rvalid_i, rdata_i (from arbiter)
//   RAM side    : mem_data, mem_write_addr, mem_read_addr, mem_EscMen
//                 (from arbiter); mem_saida (registered RAM read data)
// Modports:
//   slave  -- the arbiter view
//   master -- the environment view (requesters plus RAM)
// -----------------------------------------------------------------------------
interface arbitro_memoria_if #(
  parameter int DATA_WIDTH = arb_mem_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = arb_mem_pkg::ADDR_WIDTH
);

  logic                  req0;
  logic                  we0;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [DATA_WIDTH-1:0] wdata0;
  logic                  gnt0;
  logic                  rvalid0;
  logic [DATA_WIDTH-1:0] rdata0;

  logic                  req1;
  logic                  we1;
  logic [ADDR_WIDTH-1:0] addr1;
  logic [DATA_WIDTH-1:0] wdata1;
  logic                  gnt1;
  logic                  rvalid1;
  logic [DATA_WIDTH-1:0] rdata1;

  logic [DATA_WIDTH-1:0] mem_data;
  logic [ADDR_WIDTH-1:0] mem_write_addr;
  logic [ADDR_WIDTH-1:0] mem_read_addr;
  logic                  mem_EscMen;
  logic [DATA_WIDTH-1:0] mem_saida;

  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    input  mem_saida,
    output gnt0, rvalid0, rdata0,
    output gnt1, rvalid1, rdata1,
    output mem_data, mem_write_addr, mem_read_addr, mem_EscMen
  );

  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    output mem_saida,
    input  gnt0, rvalid0, rdata0,
    input  gnt1, rvalid1, rdata1,
    input  mem_data, mem_write_addr, mem_read_addr, mem_EscMen
  );

endinterface

// File: rtl/arbitro_memoria_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2 -- two-way round-robin arbiter for one request class.
//   clock    : clock
//   resetn   : synchronous active-low reset (pointer back to requester 0)
//   req[1:0] : requests of this class
//   gnt[1:0] : one-hot grant (combinational)
//   conflict : both requesters asked this cycle
// The 1-bit pointer names the requester favoured on the next conflict. On a
// conflict it moves to the loser; a lone requester leaves it untouched.
// -----------------------------------------------------------------------------
module rr_arb2 (
  input  logic       clock,
  input  logic       resetn,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output logic       conflict
);

  logic prio_d;
  logic prio_q;

  // Grant selection and pointer update.
  always_comb begin
    gnt      = 2'b00;
    conflict = 1'b0;
    prio_d   = prio_q;
    case (req)
      2'b01: gnt = 2'b01;
      2'b10: gnt = 2'b10;
      2'b11: begin
        conflict = 1'b1;
        if (prio_q) begin
          gnt    = 2'b10;
          prio_d = 1'b0;
        end else begin
          gnt    = 2'b01;
          prio_d = 1'b1;
        end
      end
      default: gnt = 2'b00;
    endcase
  end

  // Round-robin pointer register.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/arbitro_memoria.sv
// -----------------------------------------------------------------------------
// arbitro_memoria -- two-requester arbiter in front of the 8x64 dual-address
// RAM. Requester 0 is instruction fetch, requester 1 is load/store.
//   clock          : clock shared with the RAM (RAM writes on negedge,
//                    registers read data on posedge)
//   resetn         : synchronous active-low reset
//   bus            : arbitro_memoria_if.slave (requesters + RAM signals)
//   conflict_count : [15:0] saturating conflict counter, present only when
//                    the ARB_MEM_STATS_EN macro is defined
// Reads and writes are arbitrated independently, so one read and one write
// can be granted in the same cycle. Read data returns one cycle after the
// grant with a per-requester valid strobe.
// -----------------------------------------------------------------------------
module arbitro_memoria #(
  parameter int DATA_WIDTH = arb_mem_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = arb_mem_pkg::ADDR_WIDTH
) (
  input  logic                clock,
  input  logic                resetn,
`ifdef ARB_MEM_STATS_EN
  output logic [15:0]         conflict_count,
`endif
  arbitro_memoria_if.slave    bus
);

  import arb_mem_pkg::*;

  logic [1:0]            rd_req_s;
  logic [1:0]            wr_req_s;
  logic [1:0]            rd_gnt_s;
  logic [1:0]            wr_gnt_s;
  logic                  rd_conflict_s;
  logic                  wr_conflict_s;
  logic [ADDR_WIDTH-1:0] wr_addr_s;
  logic [DATA_WIDTH-1:0] wr_data_s;
  logic [ADDR_WIDTH-1:0] rd_addr_s;
  logic [1:0]            rvalid_d;
  logic [1:0]            rvalid_q;

  // Split requests into read and write classes; reset masks every request,
  // which forces all grants and the write enable low while resetn is 0.
  always_comb begin
    rd_req_s = 2'b00;
    wr_req_s = 2'b00;
    if (resetn) begin
      rd_req_s[REQ_FETCH] = bus.req0 & ~bus.we0;
      rd_req_s[REQ_LS]    = bus.req1 & ~bus.we1;
      wr_req_s[REQ_FETCH] = bus.req0 &  bus.we0;
      wr_req_s[REQ_LS]    = bus.req1 &  bus.we1;
    end else begin
      rd_req_s = 2'b00;
      wr_req_s = 2'b00;
    end
  end

  rr_arb2 u_rd_arb (
    .clock    (clock),
    .resetn   (resetn),
    .req      (rd_req_s),
    .gnt      (rd_gnt_s),
    .conflict (rd_conflict_s)
  );

  rr_arb2 u_wr_arb (
    .clock    (clock),
    .resetn   (resetn),
    .req      (wr_req_s),
    .gnt      (wr_gnt_s),
    .conflict (wr_conflict_s)
  );

  // Steer the winning addresses/data to the RAM; requester 0 values are
  // presented when nobody wins the class.
  always_comb begin
    wr_addr_s = bus.addr0;
    wr_data_s = bus.wdata0;
    rd_addr_s = bus.addr0;
    if (wr_gnt_s[REQ_LS]) begin
      wr_addr_s = bus.addr1;
      wr_data_s = bus.wdata1;
    end else begin
      wr_addr_s = bus.addr0;
      wr_data_s = bus.wdata0;
    end
    if (rd_gnt_s[REQ_LS]) begin
      rd_addr_s = bus.addr1;
    end else begin
      rd_addr_s = bus.addr0;
    end
  end

  // Read-valid pipeline input: the read grant of this cycle.
  always_comb begin
    rvalid_d = 2'b00;
    if (resetn) begin
      rvalid_d = rd_gnt_s;
    end else begin
      rvalid_d = 2'b00;
    end
  end

  // Read-valid pipeline register (one cycle grant-to-data latency).
  always_ff @(posedge clock) begin
    if (!resetn) begin
      rvalid_q <= 2'b00;
    end else begin
      rvalid_q <= rvalid_d;
    end
  end

  assign bus.gnt0           = rd_gnt_s[REQ_FETCH] | wr_gnt_s[REQ_FETCH];
  assign bus.gnt1           = rd_gnt_s[REQ_LS]    | wr_gnt_s[REQ_LS];
  assign bus.mem_EscMen     = |wr_gnt_s;
  assign bus.mem_write_addr = wr_addr_s;
  assign bus.mem_data       = wr_data_s;
  assign bus.mem_read_addr  = rd_addr_s;
  // Gating with resetn drops a result whose grant preceded the reset cycle.
  assign bus.rvalid0        = rvalid_q[REQ_FETCH] & resetn;
  assign bus.rvalid1        = rvalid_q[REQ_LS]    & resetn;
  assign bus.rdata0         = bus.mem_saida;
  assign bus.rdata1         = bus.mem_saida;

`ifdef ARB_MEM_STATS_EN
  logic [15:0] conflict_count_d;
  logic [15:0] conflict_count_q;

  // A cycle with both a read and a write conflict counts twice.
  always_comb begin
    conflict_count_d = sat_add16(conflict_count_q,
                                 {1'b0, rd_conflict_s} + {1'b0, wr_conflict_s});
  end

  // Conflict counter register.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      conflict_count_q <= 16'd0;
    end else begin
      conflict_count_q <= conflict_count_d;
    end
  end

  assign conflict_count = conflict_count_q;
`else
  logic unused_conflict_s;
  assign unused_conflict_s = rd_conflict_s ^ wr_conflict_s;
`endif

endmodule

// File: tb/tb_arbitro_memoria.sv
// -----------------------------------------------------------------------------
// tb_arbitro_memoria -- directed plus randomized bench for arbitro_memoria.
// Provides the RAM (negedge write, posedge registered read) and checks every
// cycle against a reference model built from the arbitration rules.
// -----------------------------------------------------------------------------
module tb_arbitro_memoria;

  import arb_mem_pkg::*;

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic clock;
  logic resetn;
`ifdef ARB_MEM_STATS_EN
  logic [15:0] conflict_count;
`endif

  arbitro_memoria_if #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) bus ();

  arbitro_memoria #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) dut (
    .clock          (clock),
    .resetn         (resetn),
`ifdef ARB_MEM_STATS_EN
    .conflict_count (conflict_count),
`endif
    .bus            (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // RAM: write at the mid-cycle negedge, registered read at posedge.
  logic [DATA_WIDTH-1:0] ram [DEPTH];
  logic [DATA_WIDTH-1:0] ram_q;
  always @(negedge clock) begin
    if (bus.mem_EscMen === 1'b1) ram[bus.mem_write_addr] <= bus.mem_data;
  end
  always @(posedge clock) ram_q <= ram[bus.mem_read_addr];
  assign bus.mem_saida = ram_q;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state.
  int                    m_rd_ptr = 0;
  int                    m_wr_ptr = 0;
  logic [DATA_WIDTH-1:0] m_mem [DEPTH];
  logic                  m_pv = 1'b0;
  int                    m_pidx = 0;
  logic [DATA_WIDTH-1:0] m_pd = '0;
  int                    m_cnt = 0;

  // Observations of the last cycle, for the directed checks.
  logic                  obs_g0, obs_g1, obs_rv0, obs_rv1;
  logic [DATA_WIDTH-1:0] obs_rd0, obs_rd1;
  logic                  last_g0, last_g1;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic req_bundle_t mk(input logic r, input logic w,
                                     input logic [ADDR_WIDTH-1:0] a,
                                     input logic [DATA_WIDTH-1:0] d);
    req_bundle_t b;
    b.req = r; b.we = w; b.addr = a; b.wdata = d;
    return b;
  endfunction

  function automatic req_bundle_t rand_bundle();
    return mk(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
              ADDR_WIDTH'($urandom_range(0, 15)), DATA_WIDTH'($urandom));
  endfunction

  // One clock cycle: drive, predict, compare, advance the model.
  task automatic run_cycle(input logic rst_i, input req_bundle_t b0, input req_bundle_t b1);
    int          rd_win, wr_win;
    logic        rd0, rd1, wr0, wr1, exp_g0, exp_g1, exp_rv0, exp_rv1;
    req_bundle_t wb, rb;
    @(posedge clock);
    #1;
    resetn = rst_i;
    bus.req0 = b0.req; bus.we0 = b0.we; bus.addr0 = b0.addr; bus.wdata0 = b0.wdata;
    bus.req1 = b1.req; bus.we1 = b1.we; bus.addr1 = b1.addr; bus.wdata1 = b1.wdata;
    #3;
    rd_win = -1; wr_win = -1;
    rd0 = rst_i & b0.req & ~b0.we;  rd1 = rst_i & b1.req & ~b1.we;
    wr0 = rst_i & b0.req &  b0.we;  wr1 = rst_i & b1.req &  b1.we;
    if (rd0 && rd1) begin rd_win = m_rd_ptr; m_rd_ptr = 1 - rd_win; end
    else if (rd0) rd_win = 0;
    else if (rd1) rd_win = 1;
    if (wr0 && wr1) begin wr_win = m_wr_ptr; m_wr_ptr = 1 - wr_win; end
    else if (wr0) wr_win = 0;
    else if (wr1) wr_win = 1;
    if (!rst_i) begin m_rd_ptr = 0; m_wr_ptr = 0; end
    wb = (wr_win == 1) ? b1 : b0;
    rb = (rd_win == 1) ? b1 : b0;
    exp_g0 = (rd_win == 0) || (wr_win == 0);
    exp_g1 = (rd_win == 1) || (wr_win == 1);
    exp_rv0 = m_pv && (m_pidx == 0) && rst_i;
    exp_rv1 = m_pv && (m_pidx == 1) && rst_i;

    check_val("gnt0", 32'(bus.gnt0), 32'(exp_g0));
    check_val("gnt1", 32'(bus.gnt1), 32'(exp_g1));
    check_val("mem_EscMen", 32'(bus.mem_EscMen), 32'(wr_win >= 0));
    if (wr_win >= 0) begin
      check_val("mem_write_addr", 32'(bus.mem_write_addr), 32'(wb.addr));
      check_val("mem_data", 32'(bus.mem_data), 32'(wb.wdata));
    end
    if (rd_win >= 0) check_val("mem_read_addr", 32'(bus.mem_read_addr), 32'(rb.addr));
    check_val("rvalid0", 32'(bus.rvalid0), 32'(exp_rv0));
    check_val("rvalid1", 32'(bus.rvalid1), 32'(exp_rv1));
    if (exp_rv0) check_val("rdata0", 32'(bus.rdata0), 32'(m_pd));
    if (exp_rv1) check_val("rdata1", 32'(bus.rdata1), 32'(m_pd));
`ifdef ARB_MEM_STATS_EN
    check_val("conflict_count", 32'(conflict_count), 32'(m_cnt));
    if (!rst_i) m_cnt = 0;
    else begin
      m_cnt = m_cnt + ((rd0 && rd1) ? 1 : 0) + ((wr0 && wr1) ? 1 : 0);
      if (m_cnt > 65535) m_cnt = 65535;
    end
`endif
    obs_g0 = bus.gnt0; obs_g1 = bus.gnt1;
    obs_rv0 = bus.rvalid0; obs_rv1 = bus.rvalid1;
    obs_rd0 = bus.rdata0; obs_rd1 = bus.rdata1;
    last_g0 = exp_g0; last_g1 = exp_g1;

    // Write-first: the write of this cycle is visible to the read of this cycle.
    if (wr_win >= 0) m_mem[wb.addr] = wb.wdata;
    m_pv = (rd_win >= 0);
    if (rd_win >= 0) begin
      m_pidx = rd_win;
      m_pd = m_mem[rb.addr];
    end
  endtask

  initial begin
    req_bundle_t idle, cur0, cur1;
    logic        rst_r;
    idle = mk(1'b0, 1'b0, '0, '0);
    resetn = 1'b0;
    bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
    bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
    repeat (2) @(posedge clock);

    // Reset held with both requesters reading; then first conflict goes to 0.
    run_cycle(1'b0, mk(1'b1, 1'b0, 6'd5, 8'h00), mk(1'b1, 1'b0, 6'd6, 8'h00));
    check_val("rst_gnt0", 32'(obs_g0), 32'd0);
    run_cycle(1'b0, mk(1'b1, 1'b0, 6'd5, 8'h00), mk(1'b1, 1'b0, 6'd6, 8'h00));
    check_val("rst_gnt1", 32'(obs_g1), 32'd0);
    run_cycle(1'b1, mk(1'b1, 1'b0, 6'd5, 8'h00), mk(1'b1, 1'b0, 6'd6, 8'h00));
    check_val("rst_first_conflict", 32'({obs_g1, obs_g0}), 32'(2'b01));
    run_cycle(1'b1, idle, mk(1'b1, 1'b0, 6'd6, 8'h00));

    // Fill the whole RAM through requester 0 so every read is predictable.
    for (int i = 0; i < DEPTH; i++)
      run_cycle(1'b1, mk(1'b1, 1'b1, ADDR_WIDTH'(i), DATA_WIDTH'($urandom)), idle);

    // Read latency.
    run_cycle(1'b1, idle, mk(1'b1, 1'b1, 6'd5, 8'hA5));
    run_cycle(1'b1, mk(1'b1, 1'b0, 6'd5, 8'h00), idle);
    check_val("lat_gnt0", 32'(obs_g0), 32'd1);
    run_cycle(1'b1, idle, idle);
    check_val("lat_rvalid0", 32'(obs_rv0), 32'd1);
    check_val("lat_rdata0", 32'(obs_rd0), 32'hA5);
    check_val("lat_rvalid1", 32'(obs_rv1), 32'd0);

    // Read conflict round-robin from a fresh pointer.
    run_cycle(1'b0, idle, idle);
    for (int k = 0; k < 4; k++) begin
      run_cycle(1'b1, mk(1'b1, 1'b0, 6'd5, 8'h00), mk(1'b1, 1'b0, 6'd9, 8'h00));
      check_val("rr_gnt0", 32'(obs_g0), 32'((k % 2) == 0));
    end
    run_cycle(1'b1, idle, idle);
    check_val("rr_last_rvalid1", 32'(obs_rv1), 32'd1);
`ifdef ARB_MEM_STATS_EN
    run_cycle(1'b1, idle, idle);
    check_val("rr_conflict_count", 32'(conflict_count), 32'd4);
`endif

    // Parallel read/write to the same address: write-first.
    run_cycle(1'b1, mk(1'b1, 1'b1, 6'd9, 8'h3C), mk(1'b1, 1'b0, 6'd9, 8'h00));
    check_val("par_gnts", 32'({obs_g1, obs_g0}), 32'(2'b11));
    run_cycle(1'b1, idle, idle);
    check_val("par_rvalid1", 32'(obs_rv1), 32'd1);
    check_val("par_rdata1", 32'(obs_rd1), 32'h3C);

    // Write conflict: requester 0 first, requester 1 on the next cycle.
    run_cycle(1'b1, mk(1'b1, 1'b1, 6'd1, 8'h11), mk(1'b1, 1'b1, 6'd1, 8'h22));
    check_val("wc_first", 32'({obs_g1, obs_g0}), 32'(2'b01));
    run_cycle(1'b1, idle, mk(1'b1, 1'b1, 6'd1, 8'h22));
    check_val("wc_second", 32'(obs_g1), 32'd1);
    run_cycle(1'b1, mk(1'b1, 1'b0, 6'd1, 8'h00), idle);
    run_cycle(1'b1, idle, idle);
    check_val("wc_rdata0", 32'(obs_rd0), 32'h22);

    // Reset right after a granted read, with the read pointer moved to 1.
    run_cycle(1'b1, mk(1'b1, 1'b0, 6'd2, 8'h00), mk(1'b1, 1'b0, 6'd3, 8'h00));
    run_cycle(1'b1, idle, mk(1'b1, 1'b0, 6'd3, 8'h00));
    run_cycle(1'b1, mk(1'b1, 1'b0, 6'd4, 8'h00), idle);
    run_cycle(1'b0, idle, idle);
    check_val("rstmid_rvalid0", 32'(obs_rv0), 32'd0);
    run_cycle(1'b1, mk(1'b1, 1'b0, 6'd2, 8'h00), mk(1'b1, 1'b0, 6'd3, 8'h00));
    check_val("rstmid_ptr0", 32'({obs_g1, obs_g0}), 32'(2'b01));
    run_cycle(1'b1, idle, mk(1'b1, 1'b0, 6'd3, 8'h00));

    // Randomized traffic; requests are held until the model says granted.
    cur0 = idle; cur1 = idle; last_g0 = 1'b0; last_g1 = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (!cur0.req || last_g0) cur0 = rand_bundle();
      if (!cur1.req || last_g1) cur1 = rand_bundle();
      rst_r = 1'($urandom_range(0, 49) != 0);
      run_cycle(rst_r, cur0, cur1);
    end
    run_cycle(1'b1, idle, idle);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
